// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the UART TX and the round-robin arbiter.
// The arbiter side uses modport master; the requester/UART side uses modport slave.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  // Handshakes: req[i] is a level held until ack[i] pulses. DATA_VALID_TX is a
  // one-cycle load strobe, accepted by a busy_flag_TX rise or rejected by data_lost_TX.
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         P_DATA_IN_TX;
  logic                          DATA_VALID_TX;
  logic                          busy_flag_TX;
  logic                          data_lost_TX;
  logic                          arb_busy;
  logic                          drop_err;
  logic                          timeout_err;
  logic [1:0]                    state_dbg;

  modport master (
    input  req, req_data, busy_flag_TX, data_lost_TX,
    output grant, ack, P_DATA_IN_TX, DATA_VALID_TX, arb_busy, drop_err, timeout_err,
           state_dbg
  );

  modport slave (
    output req, req_data, busy_flag_TX, data_lost_TX,
    input  grant, ack, P_DATA_IN_TX, DATA_VALID_TX, arb_busy, drop_err, timeout_err,
           state_dbg
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART TX among NUM_REQ requesters, one frame at a time.
// Define UART_ARB_TIMEOUT_EN to abort a load that the TX never acknowledges with busy.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              tx_clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state;
  logic [IW-1:0]           last;
  logic [IW-1:0]           owner;
  logic [NUM_REQ-1:0]      grant_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    dv_q;
  logic                    arb_busy_q;
  logic                    drop_q;

  logic [NUM_REQ-1:0]      cand;
  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [IW-1:0]           idx;
  logic [NUM_REQ-1:0]      pick_oh;
  logic [DATA_WIDTH-1:0]   sel_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_q;
`endif

  // A requester still holding req during its own ack cycle must not re-win immediately.
  assign cand = bus.req & ~ack_q;

  // Search last+1, last+2, ... ; iterating downwards lets the nearest candidate win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    idx        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (cand[idx]) begin
        pick_valid    = 1'b1;
        pick_idx      = idx;
        pick_oh       = '0;
        pick_oh[idx]  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IW'(NUM_REQ - 1);
      owner      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      arb_busy_q <= 1'b0;
      drop_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      ack_q  <= '0;
      dv_q   <= 1'b0;
      drop_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner      <= pick_idx;
            grant_q    <= pick_oh;
            data_q     <= sel_data;
            dv_q       <= 1'b1;
            arb_busy_q <= 1'b1;
            state      <= LOAD;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end
        end
        LOAD: begin
`ifdef UART_ARB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
          if (bus.data_lost_TX) begin
            drop_q     <= 1'b1;
            grant_q    <= '0;
            arb_busy_q <= 1'b0;
            state      <= IDLE;
          end else begin
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // A rejected load keeps last unchanged so the same requester retries first.
          if (bus.data_lost_TX) begin
            drop_q     <= 1'b1;
            grant_q    <= '0;
            arb_busy_q <= 1'b0;
            state      <= IDLE;
          end else if (bus.busy_flag_TX) begin
            state <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tmo_cnt >= CW'(TIMEOUT - 1)) begin
            drop_q     <= 1'b1;
            tmo_q      <= 1'b1;
            grant_q    <= '0;
            arb_busy_q <= 1'b0;
            last       <= owner;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!bus.busy_flag_TX) begin
            ack_q      <= grant_q;
            grant_q    <= '0;
            last       <= owner;
            arb_busy_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.ack           = ack_q;
  assign bus.P_DATA_IN_TX  = data_q;
  assign bus.DATA_VALID_TX = dv_q;
  assign bus.arb_busy      = arb_busy_q;
  assign bus.drop_err      = drop_q;
  assign bus.state_dbg     = state;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err   = tmo_q;
`else
  assign bus.timeout_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed request patterns, a behavioural UART TX,
// and a monitor that checks every load strobe and ack against expected queues.
module tb_uart_tx_arbiter;
  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int TMO = 8;
  localparam int W   = NR + DW;

  logic tx_clk = 1'b0;
  logic rst;
  always #5 tx_clk = ~tx_clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TMO)) dut (
    .tx_clk (tx_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [W-1:0]  exp_q[$];
  logic [NR-1:0] exp_ack_q[$];

  int            pend[NR];
  logic [DW-1:0] data_tab[NR];
  int            busy_len;
  bit            lose_next;
  bit            uart_stuck;
  int            drop_cnt = 0;
  int            tmo_seen = 0;
  int            last_dv_cyc, last_ack_cyc, busy_fall_cyc;
  logic          prev_dv = 1'b0;

  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic update_req();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]                = (pend[i] != 0);
      bus.req_data[i*DW +: DW]  = data_tab[i];
    end
  endtask

  task automatic push_frame(input int i);
    logic [NR-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    exp_q.push_back({oh, data_tab[i]});
  endtask

  task automatic push_ack(input int i);
    logic [NR-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    exp_ack_q.push_back(oh);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge tx_clk);
      done = (exp_q.size() == 0) && (exp_ack_q.size() == 0) && !bus.arb_busy;
      for (int i = 0; i < NR; i++) if (pend[i] != 0) done = 0;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge tx_clk);
    rst = 1'b0;
  endtask

  // Requesters drop their level once all of their queued frames have been acked.
  initial begin : requesters
    forever begin
      @(negedge tx_clk);
      for (int i = 0; i < NR; i++) if (bus.ack[i] && pend[i] > 0) pend[i]--;
      update_req();
    end
  end

  // Behavioural UART TX: takes the load at the strobe, or rejects it once when asked.
  initial begin : uart_model
    bus.busy_flag_TX = 1'b0;
    bus.data_lost_TX = 1'b0;
    forever begin
      @(negedge tx_clk);
      bus.data_lost_TX = 1'b0;
      if (bus.DATA_VALID_TX && !rst && !uart_stuck) begin
        if (lose_next) begin
          bus.data_lost_TX = 1'b1;
          lose_next        = 0;
        end else begin
          bus.busy_flag_TX = 1'b1;
          repeat (busy_len) @(negedge tx_clk);
          bus.busy_flag_TX = 1'b0;
          busy_fall_cyc    = cyc;
        end
      end
    end
  end

  initial begin : monitor
    logic [W-1:0]  e;
    logic [NR-1:0] ea;
    forever begin
      @(negedge tx_clk);
      if (rst) begin
        prev_dv = 1'b0;
        continue;
      end
      if (bus.grant != '0) check("grant_onehot", $countones(bus.grant), 1);
      if (bus.DATA_VALID_TX) begin
        check("dv_single_cycle", prev_dv, 0);
        last_dv_cyc = cyc;
        if (exp_q.size() == 0) fail_now("unexpected_load");
        else begin
          e = exp_q.pop_front();
          check("frame_grant_data", {bus.grant, bus.P_DATA_IN_TX}, e);
        end
      end
      prev_dv = bus.DATA_VALID_TX;
      if (bus.ack != '0) begin
        last_ack_cyc = cyc;
        check("ack_clears_grant", bus.grant, 0);
        if (exp_ack_q.size() == 0) fail_now("unexpected_ack");
        else begin
          ea = exp_ack_q.pop_front();
          check("ack_owner", bus.ack, ea);
        end
      end
      if (bus.drop_err) begin
        drop_cnt++;
        check("drop_clears_grant", bus.grant, 0);
        check("drop_no_ack", bus.ack, 0);
      end
      if (bus.timeout_err) tmo_seen++;
    end
  end

  initial begin : stimulus
    int t0, d0;
    bit hit;
    rst        = 1'b1;
    busy_len   = 3;
    lose_next  = 0;
    uart_stuck = 0;
    for (int i = 0; i < NR; i++) begin
      pend[i]     = 0;
      data_tab[i] = '0;
    end
    update_req();
    repeat (3) @(negedge tx_clk);
    check("rst_grant", bus.grant, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_dv", bus.DATA_VALID_TX, 0);
    check("rst_data", bus.P_DATA_IN_TX, 0);
    check("rst_arb_busy", bus.arb_busy, 0);
    check("rst_drop", bus.drop_err, 0);
    check("rst_timeout", bus.timeout_err, 0);
    check("rst_state", bus.state_dbg, 0);
    rst = 1'b0;
    @(negedge tx_clk);

    // Single frame with a long busy period
    data_tab[0] = 8'hA5;
    busy_len    = 40;
    push_frame(0);
    push_ack(0);
    pend[0] = 1;
    update_req();
    t0 = cyc;
    repeat (10) @(negedge tx_clk);
    check("t1_arb_busy_mid", bus.arb_busy, 1);
    check("t1_state_wait_done", bus.state_dbg, 3);
    wait_drain(200);
    check("t1_dv_latency", last_dv_cyc - t0, 1);
    check("t1_ack_latency", last_ack_cyc - busy_fall_cyc, 1);
    check("t1_arb_busy_after", bus.arb_busy, 0);

    // All four requesting: strict rotation starting from requester 0
    pulse_reset();
    busy_len = 3;
    for (int i = 0; i < NR; i++) data_tab[i] = 8'h10 + DW'(i);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) begin
        push_frame(i);
        push_ack(i);
      end
    end
    for (int i = 0; i < NR; i++) pend[i] = 2;
    update_req();
    wait_drain(300);

    // Requester 0 keeps requesting after its ack: it must alternate with requester 2
    data_tab[0] = 8'h30;
    data_tab[2] = 8'h32;
    for (int r = 0; r < 2; r++) begin
      push_frame(0); push_ack(0);
      push_frame(2); push_ack(2);
    end
    pend[0] = 2;
    pend[2] = 2;
    update_req();
    wait_drain(300);

    // Rejected load: drop, no ack, then the same requester is re-served
    data_tab[1] = 8'h41;
    d0          = drop_cnt;
    lose_next   = 1;
    push_frame(1);
    push_frame(1);
    push_ack(1);
    pend[1] = 1;
    update_req();
    wait_drain(200);
    check("t4_drop_count", drop_cnt - d0, 1);

    // Reset during WAIT_DONE aborts silently and restores requester 0 priority
    busy_len    = 20;
    data_tab[2] = 8'h52;
    data_tab[0] = 8'h50;
    push_frame(2);
    pend[2] = 1;
    update_req();
    hit = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge tx_clk);
      hit = (bus.state_dbg == 2'd3);
    end
    if (!hit) fail_now("t5_reach_wait_done");
    d0  = drop_cnt;
    rst = 1'b1;
    pend[0] = 1;
    update_req();
    push_frame(0); push_ack(0);
    push_frame(2); push_ack(2);
    @(negedge tx_clk);
    check("t5_grant", bus.grant, 0);
    check("t5_ack", bus.ack, 0);
    check("t5_dv", bus.DATA_VALID_TX, 0);
    check("t5_arb_busy", bus.arb_busy, 0);
    check("t5_drop", bus.drop_err, 0);
    check("t5_state", bus.state_dbg, 0);
    hit = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge tx_clk);
      hit = !bus.busy_flag_TX;
    end
    if (!hit) fail_now("t5_busy_release");
    rst = 1'b0;
    wait_drain(300);
    check("t5_no_drop", drop_cnt - d0, 0);

    // TX never raises busy
    data_tab[0] = 8'h60;
    data_tab[1] = 8'h61;
    uart_stuck  = 1;
    d0          = drop_cnt;
`ifdef UART_ARB_TIMEOUT_EN
    push_frame(0);
    push_frame(1); push_ack(1);
    push_frame(0); push_ack(0);
    pend[0] = 1;
    pend[1] = 1;
    update_req();
    hit = 0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge tx_clk);
      hit = bus.timeout_err;
    end
    if (!hit) fail_now("t6_timeout_seen");
    else begin
      check("t6_timeout_latency", cyc - last_dv_cyc, TMO);
      check("t6_timeout_drop", bus.drop_err, 1);
    end
    uart_stuck = 0;
    wait_drain(300);
    check("t6_tmo_count", tmo_seen, 1);
    check("t6_drop_count", drop_cnt - d0, 1);
`else
    push_frame(0); push_ack(0);
    push_frame(1); push_ack(1);
    pend[0] = 1;
    pend[1] = 1;
    update_req();
    repeat (80) @(negedge tx_clk);
    check("t6_state_wait_busy", bus.state_dbg, 2);
    check("t6_arb_busy", bus.arb_busy, 1);
    check("t6_no_timeout", tmo_seen, 0);
    check("t6_no_drop", drop_cnt - d0, 0);
    bus.busy_flag_TX = 1'b1;
    @(negedge tx_clk);
    bus.busy_flag_TX = 1'b0;
    uart_stuck       = 0;
    wait_drain(300);
    check("t6_tmo_never", tmo_seen, 0);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_ack_q_empty", exp_ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
